// File: rtl/keypad_entry_controller.sv
// Keypad entry sequencer: debounces encoder presses, collects PIN digits,
// handles clear/enter/timeout and offers a finished PIN over valid/ready.
module keypad_entry_controller #(
  parameter int unsigned PIN_LEN        = 4,
  parameter int unsigned STABLE_CYCLES  = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [3:0]                   key_code,
  input  logic                         key_valid,
  input  logic                         pin_ready,
  output logic [4*PIN_LEN-1:0]         pin_out,
  output logic                         pin_valid,
  output logic [$clog2(PIN_LEN+1)-1:0] digit_count,
  output logic                         key_accept,
  output logic                         entry_error,
  output logic                         entry_timeout
);

  localparam int unsigned PIN_W  = 4 * PIN_LEN;
  localparam int unsigned CNT_W  = $clog2(PIN_LEN + 1);
  localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0] CODE_CLEAR = 4'd10;
  localparam logic [3:0] CODE_ENTER = 4'd11;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, WAIT_RELEASE, SUBMIT} state_t;

  state_t             state_q, state_d;
  logic [3:0]         code_q, code_d;
  logic [STAB_W-1:0]  stab_q, stab_d;
  logic [STAB_W-1:0]  rel_q, rel_d;
  logic [PIN_W-1:0]   pin_buf_q, pin_buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TO_W-1:0]    idle_q, idle_d;
  logic [PIN_W-1:0]   pin_out_q, pin_out_d;
  logic               pin_valid_q, pin_valid_d;
  logic               accept_q, accept_d;
  logic               error_q, error_d;
  logic               timeout_q, timeout_d;
  logic               do_accept;
  logic [3:0]         act_code;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      code_q      <= '0;
      stab_q      <= '0;
      rel_q       <= '0;
      pin_buf_q   <= '0;
      cnt_q       <= '0;
      idle_q      <= '0;
      pin_out_q   <= '0;
      pin_valid_q <= 1'b0;
      accept_q    <= 1'b0;
      error_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      stab_q      <= stab_d;
      rel_q       <= rel_d;
      pin_buf_q   <= pin_buf_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      pin_out_q   <= pin_out_d;
      pin_valid_q <= pin_valid_d;
      accept_q    <= accept_d;
      error_q     <= error_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state, key action and inactivity timeout
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    stab_d      = stab_q;
    rel_d       = rel_q;
    pin_buf_d   = pin_buf_q;
    cnt_d       = cnt_q;
    idle_d      = idle_q;
    pin_out_d   = pin_out_q;
    pin_valid_d = pin_valid_q;
    accept_d    = 1'b0;
    error_d     = 1'b0;
    timeout_d   = 1'b0;
    do_accept   = 1'b0;
    act_code    = 4'd0;

    case (state_q)
      IDLE: begin
        if (key_valid) begin
          code_d = key_code;
          stab_d = STAB_W'(1);
          if (STABLE_CYCLES == 1) begin
            do_accept = 1'b1;
            act_code  = key_code;
            rel_d     = '0;
            state_d   = WAIT_RELEASE;
          end else begin
            state_d = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (key_valid && (key_code == code_q)) begin
          if (stab_q + STAB_W'(1) == STAB_W'(STABLE_CYCLES)) begin
            do_accept = 1'b1;
            act_code  = code_q;
            rel_d     = '0;
            state_d   = WAIT_RELEASE;
          end else begin
            stab_d = stab_q + STAB_W'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_RELEASE: begin
        if (key_valid) begin
          rel_d = '0;
        end else if (rel_q + STAB_W'(1) == STAB_W'(STABLE_CYCLES)) begin
          rel_d   = '0;
          state_d = pin_valid_q ? SUBMIT : IDLE;
        end else begin
          rel_d = rel_q + STAB_W'(1);
        end
      end
      SUBMIT: begin
        if (pin_ready) begin
          pin_valid_d = 1'b0;
          pin_buf_d   = '0;
          cnt_d       = '0;
          idle_d      = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // An accept on the timeout edge takes priority over the timeout
    if (do_accept) begin
      accept_d = 1'b1;
      idle_d   = '0;
      if (act_code <= 4'd9) begin
        if (cnt_q < CNT_W'(PIN_LEN)) begin
          pin_buf_d = PIN_W'({pin_buf_q, act_code});
          cnt_d     = cnt_q + CNT_W'(1);
        end else begin
          error_d = 1'b1;
        end
      end else if (act_code == CODE_CLEAR) begin
        pin_buf_d = '0;
        cnt_d     = '0;
      end else if (act_code == CODE_ENTER) begin
        if (cnt_q == CNT_W'(PIN_LEN)) begin
          pin_out_d   = pin_buf_q;
          pin_valid_d = 1'b1;
        end else begin
          pin_buf_d = '0;
          cnt_d     = '0;
          error_d   = 1'b1;
        end
      end
    end else if (cnt_q == '0) begin
      idle_d = '0;
    end else if (state_q != SUBMIT) begin
      if (idle_q + TO_W'(1) == TO_W'(TIMEOUT_CYCLES)) begin
        pin_buf_d = '0;
        cnt_d     = '0;
        idle_d    = '0;
        timeout_d = 1'b1;
      end else begin
        idle_d = idle_q + TO_W'(1);
      end
    end
  end

  assign pin_out       = pin_out_q;
  assign pin_valid     = pin_valid_q;
  assign digit_count   = cnt_q;
  assign key_accept    = accept_q;
  assign entry_error   = error_q;
  assign entry_timeout = timeout_q;

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Bench for keypad_entry_controller: directed scenarios plus randomized
// presses, compared every cycle against a queue-based behavioural model.
module tb_keypad_entry_controller;

  localparam int unsigned PIN_LEN = 4;
  localparam int unsigned STABLE  = 3;
  localparam int unsigned TOUT    = 20;
  localparam int unsigned PIN_W   = 4 * PIN_LEN;
  localparam int unsigned CNT_W   = $clog2(PIN_LEN + 1);
  localparam int unsigned OBS_W   = PIN_W + CNT_W + 4;

  logic             clk;
  logic             rst_n;
  logic [3:0]       key_code;
  logic             key_valid;
  logic             pin_ready;
  logic [PIN_W-1:0] pin_out;
  logic             pin_valid;
  logic [CNT_W-1:0] digit_count;
  logic             key_accept;
  logic             entry_error;
  logic             entry_timeout;

  keypad_entry_controller #(
    .PIN_LEN(PIN_LEN), .STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid),
    .pin_ready(pin_ready), .pin_out(pin_out), .pin_valid(pin_valid),
    .digit_count(digit_count), .key_accept(key_accept),
    .entry_error(entry_error), .entry_timeout(entry_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: press run lengths and a digit queue
  int               m_run, m_rel, m_idle;
  logic [3:0]       m_last;
  bit               m_hold, m_sub, m_pv, m_acc, m_err, m_to;
  int               m_digits[$];
  logic [PIN_W-1:0] m_pin;

  // Observation tallies for DUT and model
  int               diffs, acc_d, err_d, to_d, rise_d, acc_m, err_m, to_m, rise_m;
  bit               pv_prev, mpv_prev;
  logic [PIN_W-1:0] rise_pin;
  logic [OBS_W-1:0] last_dut, last_mod;

  task automatic model_reset();
    m_run = 0; m_rel = 0; m_idle = 0; m_last = 4'd0;
    m_hold = 0; m_sub = 0; m_pv = 0; m_acc = 0; m_err = 0; m_to = 0;
    m_digits.delete();
    m_pin = '0;
    pv_prev = 0; mpv_prev = 0;
  endtask

  task automatic model_edge(input bit kv, input logic [3:0] kc, input bit pr);
    bit acc = 0;
    int n0 = m_digits.size();
    bit was_sub = m_sub;
    logic [PIN_W-1:0] p;
    m_acc = 0; m_err = 0; m_to = 0;
    if (m_sub) begin
      if (pr) begin
        m_pv = 0; m_sub = 0; m_idle = 0;
        m_digits.delete();
      end
    end else if (m_hold) begin
      m_rel = kv ? 0 : m_rel + 1;
      if (m_rel == STABLE) begin
        m_hold = 0; m_rel = 0; m_sub = m_pv;
      end
    end else if (kv && (m_run == 0 || kc == m_last)) begin
      m_last = kc;
      m_run++;
      if (m_run == STABLE) begin
        acc = 1; m_run = 0; m_hold = 1; m_rel = 0;
      end
    end else begin
      m_run = 0;
    end

    if (acc) begin
      m_acc = 1; m_idle = 0;
      if (m_last <= 9) begin
        if (m_digits.size() < PIN_LEN) m_digits.push_back(int'(m_last));
        else m_err = 1;
      end else if (m_last == 10) begin
        m_digits.delete();
      end else if (m_last == 11) begin
        if (m_digits.size() == PIN_LEN) begin
          p = '0;
          foreach (m_digits[i]) p = p * 16 + PIN_W'(m_digits[i]);
          m_pin = p; m_pv = 1;
        end else begin
          m_digits.delete(); m_err = 1;
        end
      end
    end else if (n0 == 0) begin
      m_idle = 0;
    end else if (!was_sub) begin
      m_idle++;
      if (m_idle == TOUT) begin
        m_digits.delete(); m_to = 1; m_idle = 0;
      end
    end
  endtask

  // One clock: drive inputs, advance the model, record observations
  task automatic cyc(input bit kv, input logic [3:0] kc, input bit pr);
    logic [OBS_W-1:0] dv, mv;
    key_valid = kv; key_code = kc; pin_ready = pr;
    @(posedge clk);
    model_edge(kv, kc, pr);
    #1;
    dv = {pin_out, pin_valid, digit_count, key_accept, entry_error, entry_timeout};
    mv = {m_pin, m_pv, CNT_W'(m_digits.size()), m_acc, m_err, m_to};
    if (dv !== mv) begin
      diffs++; last_dut = dv; last_mod = mv;
    end
    acc_d += int'(key_accept); err_d += int'(entry_error); to_d += int'(entry_timeout);
    acc_m += int'(m_acc);      err_m += int'(m_err);       to_m += int'(m_to);
    if (pin_valid && !pv_prev) begin rise_d++; rise_pin = pin_out; end
    if (m_pv && !mpv_prev) rise_m++;
    pv_prev = pin_valid; mpv_prev = m_pv;
  endtask

  task automatic press(input logic [3:0] c, input int hold, input int gap, input bit pr);
    repeat (hold) cyc(1'b1, c, pr);
    repeat (gap) cyc(1'b0, 4'd0, pr);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'd0; pin_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pin_out, pin_valid, digit_count, key_accept, entry_error, entry_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %0h want 0",
               {pin_out, pin_valid, digit_count, key_accept, entry_error, entry_timeout});
    end
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 4'd0, 1'b0);
    checks++;
    if (diffs !== 0) begin
      errors++; $display("FAIL reset_idle_trace got %0h want %0h", last_dut, last_mod);
    end
  endtask

  task automatic test_pin_submit();
    int d0 = diffs;
    int r0 = rise_d;
    for (int i = 1; i <= 4; i++) begin
      press(4'(i), 4, 4, 1'b1);
      checks++;
      if (digit_count !== CNT_W'(i)) begin
        errors++; $display("FAIL submit_count%0d got %0d want %0d", i, digit_count, i);
      end
    end
    press(4'd11, 4, 4, 1'b1);
    checks++;
    if (rise_d - r0 !== 1 || rise_pin !== 16'h1234) begin
      errors++;
      $display("FAIL submit_pin got rises=%0d pin=%h want rises=1 pin=1234", rise_d - r0, rise_pin);
    end
    checks++;
    if (digit_count !== '0 || pin_valid !== 1'b0) begin
      errors++; $display("FAIL submit_after got cnt=%0d pv=%0b want 0 0", digit_count, pin_valid);
    end
    checks++;
    if (diffs !== d0) begin
      errors++; $display("FAIL submit_trace got %0h want %0h", last_dut, last_mod);
    end
  endtask

  task automatic test_short_press();
    int a0 = acc_d;
    press(4'd5, 2, 6, 1'b0);
    checks++;
    if (acc_d - a0 !== 0 || digit_count !== '0) begin
      errors++; $display("FAIL short_press got acc=%0d cnt=%0d want 0 0", acc_d - a0, digit_count);
    end
  endtask

  task automatic test_hold_glitch();
    int a0 = acc_d;
    int t0 = to_d;
    int d0 = diffs;
    repeat (5) cyc(1'b1, 4'd7, 1'b0);
    checks++;
    if (acc_d - a0 !== 1 || digit_count !== CNT_W'(1)) begin
      errors++; $display("FAIL hold_accept got acc=%0d cnt=%0d want 1 1", acc_d - a0, digit_count);
    end
    // 30-cycle hold outlasts the 20-cycle inactivity window
    repeat (25) cyc(1'b1, 4'd7, 1'b0);
    checks++;
    if (acc_d - a0 !== 1 || to_d - t0 !== 1 || digit_count !== '0) begin
      errors++;
      $display("FAIL hold_long got acc=%0d to=%0d cnt=%0d want 1 1 0", acc_d - a0, to_d - t0, digit_count);
    end
    cyc(1'b0, 4'd0, 1'b0); cyc(1'b0, 4'd0, 1'b0); cyc(1'b1, 4'd7, 1'b0);
    cyc(1'b0, 4'd0, 1'b0); cyc(1'b0, 4'd0, 1'b0); cyc(1'b0, 4'd0, 1'b0);
    checks++;
    if (acc_d - a0 !== 1) begin
      errors++; $display("FAIL release_glitch got acc=%0d want 1", acc_d - a0);
    end
    press(4'd7, 4, 4, 1'b0);
    checks++;
    if (acc_d - a0 !== 2 || digit_count !== CNT_W'(1)) begin
      errors++; $display("FAIL repress got acc=%0d cnt=%0d want 2 1", acc_d - a0, digit_count);
    end
    press(4'd10, 4, 4, 1'b0);
    checks++;
    if (diffs !== d0 || digit_count !== '0) begin
      errors++; $display("FAIL hold_trace got %0h want %0h", last_dut, last_mod);
    end
  endtask

  task automatic test_enter_errors();
    int e0 = err_d;
    int r0 = rise_d;
    press(4'd9, 4, 4, 1'b0); press(4'd8, 4, 4, 1'b0); press(4'd11, 4, 4, 1'b0);
    checks++;
    if (err_d - e0 !== 1 || digit_count !== '0 || rise_d !== r0) begin
      errors++;
      $display("FAIL short_enter got err=%0d cnt=%0d rises=%0d want 1 0 0", err_d - e0, digit_count, rise_d - r0);
    end
    for (int i = 1; i <= 4; i++) press(4'(i), 4, 4, 1'b0);
    checks++;
    if (err_d - e0 !== 1 || digit_count !== CNT_W'(4)) begin
      errors++; $display("FAIL full_buffer got err=%0d cnt=%0d want 1 4", err_d - e0, digit_count);
    end
    press(4'd5, 4, 4, 1'b0);
    checks++;
    if (err_d - e0 !== 2 || digit_count !== CNT_W'(4)) begin
      errors++; $display("FAIL overflow_digit got err=%0d cnt=%0d want 2 4", err_d - e0, digit_count);
    end
    press(4'd11, 4, 4, 1'b1);
    checks++;
    if (rise_d - r0 !== 1 || rise_pin !== 16'h1234 || digit_count !== '0) begin
      errors++; $display("FAIL overflow_pin got pin=%h cnt=%0d want 1234 0", rise_pin, digit_count);
    end
  endtask

  task automatic test_timeout();
    int t0 = to_d;
    int e0 = err_d;
    press(4'd4, 4, 4, 1'b0); press(4'd2, 4, 4, 1'b0);
    repeat (25) cyc(1'b0, 4'd0, 1'b0);
    checks++;
    if (to_d - t0 !== 1 || digit_count !== '0) begin
      errors++; $display("FAIL timeout got to=%0d cnt=%0d want 1 0", to_d - t0, digit_count);
    end
    press(4'd4, 4, 4, 1'b0); press(4'd2, 4, 4, 1'b0); press(4'd10, 4, 4, 1'b0);
    checks++;
    if (digit_count !== '0 || err_d !== e0 || to_d - t0 !== 1) begin
      errors++;
      $display("FAIL clear_key got cnt=%0d err=%0d to=%0d want 0 0 1", digit_count, err_d - e0, to_d - t0);
    end
  endtask

  task automatic test_submit_hold();
    int a0;
    int d0 = diffs;
    for (int i = 0; i < 4; i++) press(4'd0, 4, 4, 1'b0);
    press(4'd11, 4, 4, 1'b0);
    a0 = acc_d;
    repeat (10) cyc(1'b1, 4'd3, 1'b0);
    checks++;
    if (pin_valid !== 1'b1 || pin_out !== 16'h0000 || acc_d !== a0) begin
      errors++;
      $display("FAIL submit_stall got pv=%0b pin=%h acc=%0d want 1 0000 0", pin_valid, pin_out, acc_d - a0);
    end
    cyc(1'b0, 4'd0, 1'b1);
    checks++;
    if (pin_valid !== 1'b0 || digit_count !== '0) begin
      errors++; $display("FAIL handshake got pv=%0b cnt=%0d want 0 0", pin_valid, digit_count);
    end
    checks++;
    if (diffs !== d0) begin
      errors++; $display("FAIL submit_hold_trace got %0h want %0h", last_dut, last_mod);
    end
  endtask

  task automatic test_random();
    int d0 = diffs;
    for (int n = 0; n < 200; n++) begin
      int r = int'($urandom_range(0, 19));
      logic [3:0] c;
      int hold = int'($urandom_range(1, 6));
      int gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 25)) : int'($urandom_range(0, 5));
      bit pr = ($urandom_range(0, 3) != 0);
      if (r < 12) c = 4'($urandom_range(0, 9));
      else if (r < 16) c = 4'd11;
      else if (r < 17) c = 4'd10;
      else c = 4'($urandom_range(0, 15));
      repeat (hold) cyc(1'b1, c, pr);
      repeat (gap) cyc(1'b0, 4'($urandom), pr);
    end
    repeat (8) cyc(1'b0, 4'd0, 1'b1);
    checks++;
    if (diffs !== d0) begin
      errors++;
      $display("FAIL random_trace got %0h want %0h (%0d cycles differ)", last_dut, last_mod, diffs - d0);
    end
    checks++;
    if (acc_d !== acc_m || err_d !== err_m || to_d !== to_m || rise_d !== rise_m) begin
      errors++;
      $display("FAIL random_tallies got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               acc_d, err_d, to_d, rise_d, acc_m, err_m, to_m, rise_m);
    end
  endtask

  task automatic test_async_reset();
    int d0;
    press(4'd1, 4, 4, 1'b0);
    press(4'd2, 2, 0, 1'b0);
    checks++;
    if (digit_count !== CNT_W'(1)) begin
      errors++; $display("FAIL pre_reset_count got %0d want 1", digit_count);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({pin_out, pin_valid, digit_count, key_accept, entry_error, entry_timeout} !== '0) begin
      errors++; $display("FAIL async_reset_entry got cnt=%0d pin=%h want 0 0", digit_count, pin_out);
    end
    model_reset();
    key_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) press(4'(i + 5), 4, 4, 1'b0);
    press(4'd11, 4, 4, 1'b0);
    rst_n = 1'b0;
    #2;
    checks++;
    if (pin_valid !== 1'b0 || pin_out !== '0) begin
      errors++; $display("FAIL async_reset_submit got pv=%0b pin=%h want 0 0", pin_valid, pin_out);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    d0 = diffs;
    repeat (4) cyc(1'b0, 4'd0, 1'b1);
    checks++;
    if (diffs !== d0) begin
      errors++; $display("FAIL post_reset_trace got %0h want %0h", last_dut, last_mod);
    end
  endtask

  initial begin
    diffs = 0; acc_d = 0; err_d = 0; to_d = 0; rise_d = 0;
    acc_m = 0; err_m = 0; to_m = 0; rise_m = 0;
    rise_pin = '0; last_dut = '0; last_mod = '0;
    test_reset();
    test_pin_submit();
    test_short_press();
    test_hold_glitch();
    test_enter_errors();
    test_timeout();
    test_submit_hold();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
